tiny_riscv_fetch: RTL and testbench

//  Instruction fetch initiator driving the tiny_riscv instruction memory port (word-indexed by addr[31:2],

---
 rtl/tiny_riscv_fetch.sv | 135 +++++++++++++
 tb/tb_tiny_riscv_fetch.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tiny_riscv_fetch.sv
// Instruction fetch front end: PC, sequential read issue, response FIFO, redirect/flush.
// Optional misaligned-redirect fault enabled by `TINY_RISCV_FETCH_ALIGN_CHECK_EN.
module tiny_riscv_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  output logic [31:0] o_mem_addr,
  output logic        o_read_strobe,
  input  logic [31:0] i_mem_data,
  input  logic        i_halt,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic        o_fetch_fault
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = CW + 1;

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        fifo_q [FIFO_DEPTH];

  logic          pop, pop_eff, push, issue, fault_now;
  logic [OW-1:0] occ;

`ifdef TINY_RISCV_FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;

  always_comb begin
    fault_d   = fault_q | (i_redirect & (|i_redirect_pc[1:0]));
    fault_now = fault_d;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) fault_q <= 1'b0;
    else          fault_q <= fault_d;
  end

  assign o_fetch_fault = fault_q;
`else
  assign fault_now     = 1'b0;
  assign o_fetch_fault = 1'b0;
`endif

  assign o_instr_valid = (count_q != '0);
  assign o_mem_addr    = pc_q;
  assign o_read_strobe = issue;
  assign o_instr       = o_instr_valid ? fifo_q[rd_ptr_q].instr : 32'h0;
  assign o_instr_pc    = o_instr_valid ? fifo_q[rd_ptr_q].pc    : 32'h0;

  always_comb begin
    pop = o_instr_valid & i_instr_ready;
    // Credit: buffered + in-flight words after this cycle's pop must leave room for one more.
    occ   = {1'b0, count_q} + OW'(inflight_q) - OW'(pop);
    issue = (state_q == S_RUN) & ~i_halt & ~i_redirect & (occ < OW'(FIFO_DEPTH));

    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   if (i_halt)  state_d = S_HALT;
      S_HALT:  if (!i_halt) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
    if (fault_now) state_d = S_HALT;

    pc_d = pc_q;
    if (i_redirect)  pc_d = i_redirect_pc & ~32'h3;
    else if (issue)  pc_d = pc_q + 32'd4;

    inflight_d    = issue;
    inflight_pc_d = issue ? pc_q : inflight_pc_q;

    // A redirect discards the arriving response and any same-cycle pop.
    push    = inflight_q & ~i_redirect;
    pop_eff = pop & ~i_redirect;

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop_eff);
    count_d  = count_q + CW'(push) - CW'(pop_eff);
    if (i_redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{pc: inflight_pc_q, instr: i_mem_data};
  end

  always @(posedge i_Clk) begin
    if (i_Rst_n)
      assert (!(push && !pop_eff && (count_q == CW'(FIFO_DEPTH))));
  end

endmodule

// File: tb/tb_tiny_riscv_fetch.sv
// Directed bench for tiny_riscv_fetch (FIFO_DEPTH=4) with a registered word memory model
// returning 0x1000 + word index one cycle after each strobe.
module tb_tiny_riscv_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic        strobe;
  logic [31:0] mem_data;
  logic        halt;
  logic        redir;
  logic [31:0] rpc;
  logic [31:0] instr;
  logic [31:0] ipc;
  logic        valid;
  logic        ready;
  logic        fault;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_pc;
  bit          idle_chk;

  always #5 clk = ~clk;

  tiny_riscv_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
    .i_Clk         (clk),
    .i_Rst_n       (rst_n),
    .o_mem_addr    (addr),
    .o_read_strobe (strobe),
    .i_mem_data    (mem_data),
    .i_halt        (halt),
    .i_redirect    (redir),
    .i_redirect_pc (rpc),
    .o_instr       (instr),
    .o_instr_pc    (ipc),
    .o_instr_valid (valid),
    .i_instr_ready (ready),
    .o_fetch_fault (fault)
  );

  always @(posedge clk)
    mem_data <= strobe ? (32'h1000 + {2'b00, addr[31:2]}) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at negedge, score any accepted word, then advance past the next posedge.
  task automatic cyc();
    @(negedge clk);
    if (idle_chk) chk("idle_strobe", {31'b0, strobe}, 32'h0);
    if (valid && ready) begin
      chk("stream_pc", ipc, exp_pc);
      chk("stream_data", instr, 32'h1000 + {2'b00, exp_pc[31:2]});
      exp_pc += 32'd4;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; ready = 1'b1; halt = 1'b0; redir = 1'b0; rpc = 32'h0;
    idle_chk = 1'b0; exp_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobe", {31'b0, strobe}, 32'h0);
    chk("rst_addr",   addr,            32'h0);
    chk("rst_valid",  {31'b0, valid},  32'h0);
    chk("rst_instr",  instr,           32'h0);
    chk("rst_ipc",    ipc,             32'h0);
    chk("rst_fault",  {31'b0, fault},  32'h0);

    // Boot cycle, then strobes at 0 and 4, first valid three cycles after release.
    rst_n = 1'b1;
    @(negedge clk); chk("boot_strobe", {31'b0, strobe}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("c1_strobe", {31'b0, strobe}, 32'h1);
    chk("c1_addr",   addr,            32'h0);
    chk("c1_valid",  {31'b0, valid},  32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("c2_addr",  addr,           32'h4);
    chk("c2_valid", {31'b0, valid}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("first_valid", {31'b0, valid}, 32'h1);
    chk("first_instr", instr,          32'h1000);
    chk("first_pc",    ipc,            32'h0);
    @(posedge clk); #1;
    exp_pc = 32'h4;
    repeat (6) cyc();
    chk("t1_progress", exp_pc, 32'h1C);

    // Downstream stall: four words buffered, strobes stop, resume without loss.
    ready = 1'b0;
    repeat (10) cyc();
    @(negedge clk);
    chk("stall_strobe", {31'b0, strobe}, 32'h0);
    chk("stall_valid",  {31'b0, valid},  32'h1);
    chk("stall_head",   ipc,             32'h1C);
    chk("stall_addr",   addr,            32'h2C);
    @(posedge clk); #1;
    ready = 1'b1;
    repeat (8) cyc();
    chk("t2_progress", exp_pc, 32'h3C);

    // Redirect coincident with a pop of the head.
    redir = 1'b1; rpc = 32'h80;
    @(negedge clk);
    chk("rp_valid",  {31'b0, valid},  32'h1);
    chk("rp_strobe", {31'b0, strobe}, 32'h0);
    @(posedge clk); #1;
    redir = 1'b0; exp_pc = 32'h80;
    @(negedge clk);
    chk("rp1_valid",  {31'b0, valid},  32'h0);
    chk("rp1_strobe", {31'b0, strobe}, 32'h1);
    chk("rp1_addr",   addr,            32'h80);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rp2_valid", {31'b0, valid}, 32'h0);
    chk("rp2_addr",  addr,           32'h84);
    @(posedge clk); #1;
    repeat (4) cyc();
    chk("t4_progress", exp_pc, 32'h90);

    // Redirect to 0x40 with two buffered words and one in flight.
    ready = 1'b0;
    cyc();
    redir = 1'b1; rpc = 32'h40;
    @(negedge clk);
    chk("rf_valid",  {31'b0, valid},  32'h1);
    chk("rf_strobe", {31'b0, strobe}, 32'h0);
    @(posedge clk); #1;
    redir = 1'b0; ready = 1'b1; exp_pc = 32'h40;
    @(negedge clk);
    chk("rf1_valid",  {31'b0, valid},  32'h0);
    chk("rf1_strobe", {31'b0, strobe}, 32'h1);
    chk("rf1_addr",   addr,            32'h40);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rf2_valid", {31'b0, valid}, 32'h0);
    @(posedge clk); #1;
    repeat (4) cyc();
    chk("t3_progress", exp_pc, 32'h50);

    // Halt for 5 cycles: no strobes, in-flight and buffered words still delivered.
    halt = 1'b1; idle_chk = 1'b1;
    repeat (5) cyc();
    chk("halt_drain", exp_pc, 32'h58);
    halt = 1'b0;
    cyc();
    idle_chk = 1'b0;
    @(negedge clk);
    chk("unhalt_strobe", {31'b0, strobe}, 32'h1);
    chk("unhalt_addr",   addr,            32'h58);
    @(posedge clk); #1;
    repeat (4) cyc();
    chk("t5_progress", exp_pc, 32'h64);

    // Misaligned redirect target.
    redir = 1'b1; rpc = 32'h42;
    @(negedge clk);
    chk("ma_strobe", {31'b0, strobe}, 32'h0);
    @(posedge clk); #1;
    redir = 1'b0;
`ifdef TINY_RISCV_FETCH_ALIGN_CHECK_EN
    @(negedge clk);
    chk("ma_fault", {31'b0, fault}, 32'h1);
    @(posedge clk); #1;
    idle_chk = 1'b1;
    repeat (6) cyc();
    idle_chk = 1'b0;
    chk("ma_fault_sticky", {31'b0, fault}, 32'h1);
`else
    exp_pc = 32'h40;
    @(negedge clk);
    chk("ma_fault",  {31'b0, fault},  32'h0);
    chk("ma_strobe1", {31'b0, strobe}, 32'h1);
    chk("ma_addr",   addr,            32'h40);
    @(posedge clk); #1;
    repeat (4) cyc();
    chk("t6_progress", exp_pc, 32'h4C);

    // PC wrap through the top of the address space.
    redir = 1'b1; rpc = 32'hFFFF_FFF8;
    @(posedge clk); #1;
    redir = 1'b0; exp_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    chk("wrap_addr", addr, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    repeat (6) cyc();
    chk("wrap_progress", exp_pc, 32'h0000_000C);
`endif

    // Asynchronous reset mid-stream.
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_strobe", {31'b0, strobe}, 32'h0);
    chk("mid_rst_valid",  {31'b0, valid},  32'h0);
    chk("mid_rst_addr",   addr,            32'h0);
    chk("mid_rst_instr",  instr,           32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
